win_scan_sched: RTL and testbench

WIN_SCAN_SCHED -- requirements
Module: win_scan_sched

---
 rtl/win_scan_sched.sv | 158 +++++++++++++++
 tb/tb_win_scan_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_scan_sched.sv
// win_scan_sched -- sliding-window scan scheduler.
//
// Walks a (row, block) grid of window start positions and hands each one to
// a window loader through a ready/start/done handshake. Rows advance by a
// configurable stride (0 behaves as 1). Blocks advance by 1 inside a row.
// The scan ends once the next row would pass the last legal start row.
//
// Parameters:
//   Y_W   - row counter width
//   BLK_W - block counter width
//   WIN_W - window-size field width
//
// Ports:
//   clk, rst             - clock (rising edge) and asynchronous active-high reset
//   cfg_start            - one-cycle pulse that begins a scan (ignored while busy)
//   cfg_win_size         - window size for the scan
//   cfg_max_y            - last legal start row
//   cfg_step_y           - row stride
//   cfg_max_block        - last legal start block
//   busy / scan_done     - scan in progress / one-cycle completion pulse
//   ld_ready / ld_done   - loader idle / loader finished the current window
//   ld_start             - one-cycle start pulse to the loader
//   ld_win_size, ld_start_y, ld_start_block - window presented to the loader
//   abort                - present only when WINSCHED_ABORT_EN is defined
//
// Optional feature macro: WINSCHED_ABORT_EN (adds the abort input).
module win_scan_sched #(
  parameter int Y_W   = 9,
  parameter int BLK_W = 4,
  parameter int WIN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [WIN_W-1:0] cfg_win_size,
  input  logic [Y_W-1:0]   cfg_max_y,
  input  logic [Y_W-1:0]   cfg_step_y,
  input  logic [BLK_W-1:0] cfg_max_block,
`ifdef WINSCHED_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             scan_done,
  input  logic             ld_ready,
  output logic             ld_start,
  output logic [WIN_W-1:0] ld_win_size,
  output logic [Y_W-1:0]   ld_start_y,
  output logic [BLK_W-1:0] ld_start_block,
  input  logic             ld_done
);

  typedef enum logic [2:0] {
    S_Reset,
    S_Idle,
    S_Issue,
    S_Wait,
    S_Advance,
    S_Done
  } state_t;

  state_t           state_q;
  logic [Y_W-1:0]   y_q;
  logic [BLK_W-1:0] block_q;
  logic [WIN_W-1:0] win_q;
  logic [Y_W-1:0]   max_y_q;
  logic [Y_W-1:0]   step_q;
  logic [BLK_W-1:0] max_block_q;
  logic             abort_pend_q;
  logic             abort_w;
  logic [Y_W:0]     y_sum;

`ifdef WINSCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // One extra bit so a large stride cannot wrap back to a small row.
  assign y_sum = {1'b0, y_q} + {1'b0, step_q};

  // ld_start is decoded from the state plus ld_ready so the loader sees the
  // start in the same cycle it becomes ready; this keeps the done-to-start
  // turnaround at two cycles. It is suppressed in an abort cycle.
  assign ld_start       = (state_q == S_Issue) && ld_ready && !abort_w;
  assign busy           = (state_q == S_Issue) || (state_q == S_Wait) ||
                          (state_q == S_Advance) || (state_q == S_Done);
  assign scan_done      = (state_q == S_Done);
  assign ld_win_size    = win_q;
  assign ld_start_y     = y_q;
  assign ld_start_block = block_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_Reset;
      y_q          <= '0;
      block_q      <= '0;
      win_q        <= '0;
      max_y_q      <= '0;
      step_q       <= '0;
      max_block_q  <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_Reset: state_q <= S_Idle;

        S_Idle: begin
          abort_pend_q <= 1'b0;
          if (cfg_start) begin
            win_q       <= cfg_win_size;
            max_y_q     <= cfg_max_y;
            step_q      <= (cfg_step_y == '0) ? Y_W'(1) : cfg_step_y;
            max_block_q <= cfg_max_block;
            y_q         <= '0;
            block_q     <= '0;
            state_q     <= S_Issue;
          end
        end

        S_Issue: begin
          if (abort_w)       state_q <= S_Idle;
          else if (ld_ready) state_q <= S_Wait;
        end

        // The loader owns the window now; an abort only takes effect once
        // it reports done, so the loader is never left mid-transfer.
        S_Wait: begin
          if (abort_w) abort_pend_q <= 1'b1;
          if (ld_done) begin
            if (abort_pend_q || abort_w) state_q <= S_Idle;
            else                         state_q <= S_Advance;
          end
        end

        S_Advance: begin
          if (abort_w) begin
            state_q <= S_Idle;
          end else if (block_q < max_block_q) begin
            block_q <= block_q + 1'b1;
            state_q <= S_Issue;
          end else begin
            block_q <= '0;
            if (y_sum > {1'b0, max_y_q}) begin
              state_q <= S_Done;
            end else begin
              y_q     <= y_sum[Y_W-1:0];
              state_q <= S_Issue;
            end
          end
        end

        S_Done:  state_q <= S_Idle;

        default: state_q <= S_Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_win_scan_sched.sv
// Directed testbench for win_scan_sched (default build, no abort port).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_win_scan_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [4:0] cfg_win_size;
  logic [8:0] cfg_max_y;
  logic [8:0] cfg_step_y;
  logic [3:0] cfg_max_block;
  logic       busy;
  logic       scan_done;
  logic       ld_ready;
  logic       ld_start;
  logic [4:0] ld_win_size;
  logic [8:0] ld_start_y;
  logic [3:0] ld_start_block;
  logic       ld_done;

  int errors = 0;
  int checks = 0;
  int obs_y[$];
  int obs_b[$];
  int dones;

  always #5 clk = ~clk;

  win_scan_sched #(.Y_W(9), .BLK_W(4), .WIN_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_win_size   (cfg_win_size),
    .cfg_max_y      (cfg_max_y),
    .cfg_step_y     (cfg_step_y),
    .cfg_max_block  (cfg_max_block),
    .busy           (busy),
    .scan_done      (scan_done),
    .ld_ready       (ld_ready),
    .ld_start       (ld_start),
    .ld_win_size    (ld_win_size),
    .ld_start_y     (ld_start_y),
    .ld_start_block (ld_start_block),
    .ld_done        (ld_done)
  );

  // Runs one scan with an always-ready loader that answers ld_done three
  // cycles after each start; records every (y, block) issued.
  task automatic run_scan(input logic [8:0] my, input logic [8:0] st,
                          input logic [3:0] mb, input logic [4:0] ws);
    int cnt;
    bit finished;
    obs_y.delete();
    obs_b.delete();
    dones    = 0;
    cnt      = -1;
    finished = 0;
    ld_ready = 1'b1;
    ld_done  = 1'b0;
    @(negedge clk);
    cfg_max_y = my; cfg_step_y = st; cfg_max_block = mb; cfg_win_size = ws;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      ld_done = 1'b0;
      if (ld_start) begin
        obs_y.push_back(int'(ld_start_y));
        obs_b.push_back(int'(ld_start_block));
        checks++;
        if (ld_win_size !== ws) begin
          errors++;
          $display("FAIL scan_win_size: got %0d want %0d", ld_win_size, ws);
        end
        cnt = 3;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ld_done = 1'b1;
      end
      if (scan_done) begin
        dones++;
        finished = 1;
      end
      @(negedge clk);
    end
    ld_done = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL scan_timeout: no scan_done within 3000 cycles (got 0 want 1)");
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL scan_busy_after_done: got %0b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_win_size = 0; cfg_max_y = 0;
    cfg_step_y = 0; cfg_max_block = 0; ld_ready = 0; ld_done = 0;
    @(negedge clk);
    checks++;
    if ({busy, scan_done, ld_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000", {busy, scan_done, ld_start});
    end
    checks++;
    if ({ld_win_size, ld_start_y, ld_start_block} !== 18'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {ld_win_size, ld_start_y, ld_start_block});
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int ey[6] = '{0, 0, 2, 2, 4, 4};
    int eb[6] = '{0, 1, 0, 1, 0, 1};
    run_scan(9'd4, 9'd2, 4'd1, 5'd9);
    checks++;
    if (obs_y.size() != 6) begin
      errors++;
      $display("FAIL basic_count: got %0d want 6", obs_y.size());
    end
    for (int i = 0; i < 6 && i < obs_y.size(); i++) begin
      checks++;
      if (obs_y[i] != ey[i] || obs_b[i] != eb[i]) begin
        errors++;
        $display("FAIL basic_pos[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 i, obs_y[i], obs_b[i], ey[i], eb[i]);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL basic_done: got %0d want 1", dones);
    end
  endtask

  task automatic test_step_zero();
    int ey[2] = '{0, 1};
    run_scan(9'd1, 9'd0, 4'd0, 5'd3);
    checks++;
    if (obs_y.size() != 2) begin
      errors++;
      $display("FAIL step0_count: got %0d want 2", obs_y.size());
    end
    for (int i = 0; i < 2 && i < obs_y.size(); i++) begin
      checks++;
      if (obs_y[i] != ey[i] || obs_b[i] != 0) begin
        errors++;
        $display("FAIL step0_pos[%0d]: got (%0d,%0d) want (%0d,0)", i, obs_y[i], obs_b[i], ey[i]);
      end
    end
  endtask

  task automatic test_no_wrap();
    int ey[2] = '{0, 300};
    run_scan(9'd511, 9'd300, 4'd0, 5'd31);
    checks++;
    if (obs_y.size() != 2) begin
      errors++;
      $display("FAIL nowrap_count: got %0d want 2", obs_y.size());
    end
    for (int i = 0; i < 2 && i < obs_y.size(); i++) begin
      checks++;
      if (obs_y[i] != ey[i]) begin
        errors++;
        $display("FAIL nowrap_y[%0d]: got %0d want %0d", i, obs_y[i], ey[i]);
      end
    end
  endtask

  task automatic test_single_and_wide();
    int ey[6] = '{0, 0, 0, 3, 3, 3};
    int eb[6] = '{0, 1, 2, 0, 1, 2};
    run_scan(9'd0, 9'd5, 4'd0, 5'd1);
    checks++;
    if (obs_y.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", obs_y.size());
    end
    run_scan(9'd5, 9'd3, 4'd2, 5'd17);
    checks++;
    if (obs_y.size() != 6) begin
      errors++;
      $display("FAIL wide_count: got %0d want 6", obs_y.size());
    end
    for (int i = 0; i < 6 && i < obs_y.size(); i++) begin
      checks++;
      if (obs_y[i] != ey[i] || obs_b[i] != eb[i]) begin
        errors++;
        $display("FAIL wide_pos[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 i, obs_y[i], obs_b[i], ey[i], eb[i]);
      end
    end
  endtask

  task automatic test_ready_hold();
    bit seen;
    ld_ready = 1'b0;
    ld_done  = 1'b0;
    @(negedge clk);
    cfg_max_y = 9'd0; cfg_step_y = 9'd1; cfg_max_block = 4'd0; cfg_win_size = 5'd7;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // A second start with different config while busy must be ignored.
      if (i == 3) begin cfg_start = 1'b1; cfg_win_size = 5'd3; cfg_max_y = 9'd8; end
      else cfg_start = 1'b0;
      checks++;
      if (ld_start !== 1'b0 || busy !== 1'b1 || ld_win_size !== 5'd7) begin
        errors++;
        $display("FAIL hold_cycle%0d: got start=%0b busy=%0b win=%0d want 0 1 7",
                 i, ld_start, busy, ld_win_size);
      end
      @(negedge clk);
    end
    cfg_start = 1'b0;
    ld_ready  = 1'b1;
    #1;
    checks++;
    if (ld_start !== 1'b1 || ld_start_y !== 9'd0 || ld_win_size !== 5'd7) begin
      errors++;
      $display("FAIL hold_release: got start=%0b y=%0d win=%0d want 1 0 7",
               ld_start, ld_start_y, ld_win_size);
    end
    @(negedge clk);
    checks++;
    if (ld_start !== 1'b0) begin
      errors++;
      $display("FAIL hold_single_pulse: got %0b want 0", ld_start);
    end
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (scan_done) seen = 1;
      checks++;
      if (ld_start !== 1'b0) begin
        errors++;
        $display("FAIL hold_extra_start: got 1 want 0");
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_done: got no scan_done want 1");
    end
  endtask

  task automatic test_reset_mid_scan();
    int starts;
    bit bad;
    ld_ready = 1'b1;
    ld_done  = 1'b0;
    starts   = 0;
    @(negedge clk);
    cfg_max_y = 9'd4; cfg_step_y = 9'd2; cfg_max_block = 4'd1; cfg_win_size = 5'd5;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 40 && starts < 2; i++) begin
      ld_done = 1'b0;
      if (ld_start) begin
        starts++;
        if (starts == 1) begin @(negedge clk); ld_done = 1'b1; end
      end
      @(negedge clk);
    end
    ld_done = 1'b0;
    checks++;
    if (starts != 2 || ld_start_block !== 4'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got starts=%0d block=%0d busy=%0b want 2 1 1",
               starts, ld_start_block, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, scan_done, ld_start, ld_win_size, ld_start_y, ld_start_block} !== 21'd0) begin
      errors++;
      $display("FAIL mid_async_clear: got %h want 0",
               {busy, scan_done, ld_start, ld_win_size, ld_start_y, ld_start_block});
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (scan_done || busy || ld_start) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_no_resume: got activity after reset want none");
    end
    run_scan(9'd4, 9'd2, 4'd1, 5'd5);
    checks++;
    if (obs_y.size() != 6 || obs_y[0] != 0 || obs_b[0] != 0) begin
      errors++;
      $display("FAIL mid_restart: got count=%0d first=(%0d,%0d) want 6 (0,0)",
               obs_y.size(), (obs_y.size() > 0) ? obs_y[0] : -1,
               (obs_b.size() > 0) ? obs_b[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step_zero();
    test_no_wrap();
    test_single_and_wide();
    test_ready_hold();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
